// File: rtl/cell_packet_checker.sv
// cell_packet_checker
//
// Receive-side checker for the Aurora BPM packet stream on a cell CCW/CW
// AXI-Stream link. It parses 5-word packets (header, X, Y, S, CRC), validates
// the magic, the packet length and the CRC word, and presents the decoded
// fields of good packets with a one-cycle strobe. It also keeps saturating
// good/error counters and a bitmap of the cell indices received.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast
//                   input stream; there is no tready, every valid beat is taken
//   clear           synchronous clear of good_count, err_count and cells_seen
//   pkt_valid       one-cycle strobe, good packet decoded
//   pkt_fofb_en, pkt_cell_index, pkt_fofb_index
//                   header fields of the last good packet
//   pkt_x, pkt_y    words 1 and 2 of the last good packet
//   pkt_crc_fault, pkt_clip, pkt_sum
//                   word 3 fields of the last good packet
//   err_magic, err_len, err_crc
//                   one-cycle error strobes, at most one per packet
//   good_count, err_count
//                   saturating packet counters
//   cells_seen      bit n set once a good packet with cell index n arrives
//   busy            high while a packet is being parsed (state is not HDR)
module cell_packet_checker #(
  parameter logic [15:0] MAGIC        = 16'hA5BE,
  parameter bit          CHECK_CRC    = 1'b1,
  parameter logic [31:0] EXPECTED_CRC = 32'hADADFACE,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  input  logic             clear,
  output logic             pkt_valid,
  output logic             pkt_fofb_en,
  output logic [4:0]       pkt_cell_index,
  output logic [8:0]       pkt_fofb_index,
  output logic [31:0]      pkt_x,
  output logic [31:0]      pkt_y,
  output logic             pkt_crc_fault,
  output logic             pkt_clip,
  output logic [29:0]      pkt_sum,
  output logic             err_magic,
  output logic             err_len,
  output logic             err_crc,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      cells_seen,
  output logic             busy
);

  typedef enum logic [2:0] {
    StHdr,
    StW1,
    StW2,
    StW3,
    StCrc,
    StDiscard
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e      state_q;

  // Fields of the packet in flight; they only reach the outputs on a good CRC beat.
  logic        hdr_fofb_en_q;
  logic [4:0]  hdr_cell_q;
  logic [8:0]  hdr_fofb_idx_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [31:0] s_q;

  logic magic_ok;
  logic crc_ok;
  logic good_evt;
  logic magic_evt;
  logic len_evt;
  logic crc_evt;
  logic err_evt;

  assign magic_ok = (s_tdata[31:16] == MAGIC);
  assign crc_ok   = !CHECK_CRC || (s_tdata == EXPECTED_CRC);

  // Classify the current beat. Shared by the FSM and the counters so that the
  // strobes and the counter/bitmap updates land on the same edge.
  always_comb begin
    good_evt  = 1'b0;
    magic_evt = 1'b0;
    len_evt   = 1'b0;
    crc_evt   = 1'b0;
    if (s_tvalid) begin
      unique case (state_q)
        StHdr: begin
          if (!magic_ok) begin
            magic_evt = 1'b1;
          end else if (s_tlast) begin
            len_evt = 1'b1;
          end
        end
        StW1, StW2, StW3: begin
          len_evt = s_tlast;
        end
        StCrc: begin
          if (!s_tlast) begin
            len_evt = 1'b1;
          end else if (!crc_ok) begin
            crc_evt = 1'b1;
          end else begin
            good_evt = 1'b1;
          end
        end
        // DISCARD raises nothing: the packet has already been reported.
        default: ;
      endcase
    end
  end

  assign err_evt = magic_evt | len_evt | crc_evt;

  // Parser FSM with registered strobes and decoded-field outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StHdr;
      hdr_fofb_en_q  <= 1'b0;
      hdr_cell_q     <= '0;
      hdr_fofb_idx_q <= '0;
      x_q            <= '0;
      y_q            <= '0;
      s_q            <= '0;
      pkt_valid      <= 1'b0;
      pkt_fofb_en    <= 1'b0;
      pkt_cell_index <= '0;
      pkt_fofb_index <= '0;
      pkt_x          <= '0;
      pkt_y          <= '0;
      pkt_crc_fault  <= 1'b0;
      pkt_clip       <= 1'b0;
      pkt_sum        <= '0;
      err_magic      <= 1'b0;
      err_len        <= 1'b0;
      err_crc        <= 1'b0;
    end else begin
      pkt_valid <= good_evt;
      err_magic <= magic_evt;
      err_len   <= len_evt;
      err_crc   <= crc_evt;

      if (good_evt) begin
        pkt_fofb_en    <= hdr_fofb_en_q;
        pkt_cell_index <= hdr_cell_q;
        pkt_fofb_index <= hdr_fofb_idx_q;
        pkt_x          <= x_q;
        pkt_y          <= y_q;
        pkt_crc_fault  <= s_q[31];
        pkt_clip       <= s_q[30];
        pkt_sum        <= s_q[29:0];
      end

      if (s_tvalid) begin
        unique case (state_q)
          StHdr: begin
            if (!magic_ok) begin
              // A one-beat bad packet is already over; otherwise drop the rest.
              state_q <= s_tlast ? StHdr : StDiscard;
            end else if (!s_tlast) begin
              hdr_fofb_en_q  <= s_tdata[15];
              hdr_cell_q     <= s_tdata[14:10];
              hdr_fofb_idx_q <= s_tdata[8:0];
              state_q        <= StW1;
            end
          end
          StW1: begin
            x_q     <= s_tdata;
            state_q <= s_tlast ? StHdr : StW2;
          end
          StW2: begin
            y_q     <= s_tdata;
            state_q <= s_tlast ? StHdr : StW3;
          end
          StW3: begin
            s_q     <= s_tdata;
            state_q <= s_tlast ? StHdr : StCrc;
          end
          StCrc: begin
            state_q <= s_tlast ? StHdr : StDiscard;
          end
          StDiscard: begin
            if (s_tlast) begin
              state_q <= StHdr;
            end
          end
          default: state_q <= StHdr;
        endcase
      end
    end
  end

  // Saturating counters and cell bitmap; clear takes priority over any update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_count <= '0;
      err_count  <= '0;
      cells_seen <= '0;
    end else if (clear) begin
      good_count <= '0;
      err_count  <= '0;
      cells_seen <= '0;
    end else begin
      if (good_evt && (good_count != CntMax)) begin
        good_count <= good_count + CNT_W'(1);
      end
      if (err_evt && (err_count != CntMax)) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (good_evt) begin
        cells_seen[hdr_cell_q] <= 1'b1;
      end
    end
  end

  assign busy = (state_q != StHdr);

endmodule

// File: tb/tb_cell_packet_checker.sv
// Scoreboard bench for cell_packet_checker. Two instances share one stimulus
// stream: instance 0 checks the CRC word, instance 1 accepts any CRC word.
// Counters are narrowed so that saturation is reachable in a short run.
module tb_cell_packet_checker;

  localparam int unsigned CntW  = 8;
  localparam logic [31:0] Crc   = 32'hADADFACE;
  localparam logic [15:0] Magic = 16'hA5BE;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        clear;

  logic            pv [2];
  logic            fe [2];
  logic [4:0]      ci [2];
  logic [8:0]      fi [2];
  logic [31:0]     px [2];
  logic [31:0]     py [2];
  logic            cf [2];
  logic            cl [2];
  logic [29:0]     sm [2];
  logic            em [2];
  logic            el [2];
  logic            ec [2];
  logic [CntW-1:0] gc [2];
  logic [CntW-1:0] erc[2];
  logic [31:0]     cs [2];
  logic            bz [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cell_packet_checker #(
      .MAGIC       (Magic),
      .CHECK_CRC   (g == 0),
      .EXPECTED_CRC(Crc),
      .CNT_W       (CntW)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tlast       (s_tlast),
      .clear         (clear),
      .pkt_valid     (pv[g]),
      .pkt_fofb_en   (fe[g]),
      .pkt_cell_index(ci[g]),
      .pkt_fofb_index(fi[g]),
      .pkt_x         (px[g]),
      .pkt_y         (py[g]),
      .pkt_crc_fault (cf[g]),
      .pkt_clip      (cl[g]),
      .pkt_sum       (sm[g]),
      .err_magic     (em[g]),
      .err_len       (el[g]),
      .err_crc       (ec[g]),
      .good_count    (gc[g]),
      .err_count     (erc[g]),
      .cells_seen    (cs[g]),
      .busy          (bz[g])
    );
  end

  // Expected strobe pattern is {pkt_valid, err_magic, err_len, err_crc}.
  typedef struct {
    logic [3:0]      strobe;
    logic [110:0]    flds;
    logic [CntW-1:0] good;
    logic [CntW-1:0] err;
    logic [31:0]     cells;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [CntW-1:0] good_m [2];
  logic [CntW-1:0] err_m  [2];
  logic [31:0]     cells_m[2];
  logic [110:0]    flds_m [2];

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet outcome from the packet rules: 0 good, 1 bad magic, 2 bad length, 3 bad CRC.
  function automatic int outcome(input logic [31:0] w[$], input bit chk);
    if (w[0][31:16] != Magic) return 1;
    if (w.size() != 5) return 2;
    if (chk && w[4] != Crc) return 3;
    return 0;
  endfunction

  function automatic logic [3:0] strobe_of(input int k);
    case (k)
      0:       return 4'b1000;
      1:       return 4'b0100;
      2:       return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      good_m[i]  = '0;
      err_m[i]   = '0;
      cells_m[i] = '0;
      flds_m[i]  = '0;
    end
  endtask

  task automatic expect_pkt(input logic [31:0] w[$], input bit clr);
    exp_t e;
    int   k;
    for (int i = 0; i < 2; i++) begin
      k = outcome(w, i == 0);
      if (clr) begin
        good_m[i]  = '0;
        err_m[i]   = '0;
        cells_m[i] = '0;
      end else if (k == 0) begin
        if (good_m[i] != {CntW{1'b1}}) good_m[i] = good_m[i] + 1;
        cells_m[i][w[0][14:10]] = 1'b1;
      end else begin
        if (err_m[i] != {CntW{1'b1}}) err_m[i] = err_m[i] + 1;
      end
      if (k == 0) begin
        flds_m[i] = {w[0][15], w[0][14:10], w[0][8:0], w[1], w[2],
                     w[3][31], w[3][30], w[3][29:0]};
      end
      e.strobe = strobe_of(k);
      e.flds   = flds_m[i];
      e.good   = good_m[i];
      e.err    = err_m[i];
      e.cells  = cells_m[i];
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input bit clr);
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    clear    = clr;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    clear    = 1'b0;
    s_tdata  = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input logic [31:0] w[$], input int gmin, input int gmax,
                          input bit clr);
    int decide;
    expect_pkt(w, clr);
    if (w[0][31:16] != Magic) decide = 0;
    else if (w.size() > 5) decide = 4;
    else decide = w.size() - 1;
    for (int j = 0; j < w.size(); j++) begin
      send_beat(w[j], j == w.size() - 1, clr && (j == w.size() - 1));
      if (j == decide) begin
        check("strobe_latency", {pv[0] | em[0] | el[0] | ec[0]}, 1);
      end
      idle($urandom_range(gmax, gmin));
    end
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      check("reset_fields", {fe[i], ci[i], fi[i], px[i], py[i], cf[i], cl[i], sm[i]}, 0);
      check("reset_flags", {pv[i], em[i], el[i], ec[i], gc[i], erc[i], cs[i], bz[i]}, 0);
    end
  endtask

  function automatic logic [31:0] good_hdr();
    logic [31:0] h;
    h = $urandom;
    h[31:16] = Magic;
    return h;
  endfunction

  // Monitor: every strobe pops one expectation from that instance's queue.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] obs;
    int         sz;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        obs = {pv[i], em[i], el[i], ec[i]};
        sz  = (i == 0) ? q0.size() : q1.size();
        if (obs != 4'b0000) begin
          if (sz == 0) begin
            check("unexpected_strobe", obs, 0);
          end else begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check("strobe", obs, e.strobe);
            check("pkt_fields", {fe[i], ci[i], fi[i], px[i], py[i], cf[i], cl[i], sm[i]},
                  e.flds);
            check("good_count", gc[i], e.good);
            check("err_count", erc[i], e.err);
            check("cells_seen", cs[i], e.cells);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] w[$];
    int          len;
    int          pick;

    rst      = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    clear    = 1'b0;
    model_reset();
    idle(3);
    check_reset_outputs();
    rst = 1'b0;
    idle(2);

    // Directed good packet, one idle cycle between beats.
    w = '{32'hA5BE8C00, 32'h00000064, 32'hFFFFFF9C, 32'h40000010, Crc};
    send_pkt(w, 1, 1, 1'b0);
    idle(2);
    check("busy_idle", bz[0], 0);

    // Bad magic, then a good packet.
    w = '{32'h12348C00, 32'h1, 32'h2, 32'h3, Crc};
    send_pkt(w, 0, 1, 1'b0);
    w = '{32'hA5BE1400, 32'h11, 32'h22, 32'h80000033, Crc};
    send_pkt(w, 0, 1, 1'b0);

    // Short packet (tlast on word 2), good packet, then a 6-beat packet.
    w = '{32'hA5BE0800, 32'h5, 32'h6};
    send_pkt(w, 0, 0, 1'b0);
    w = '{32'hA5BE8C05, 32'h7, 32'h8, 32'h9, Crc};
    send_pkt(w, 0, 0, 1'b0);
    w = '{32'hA5BE0C00, 32'h5, 32'h6, 32'h7, Crc, 32'hAA};
    send_pkt(w, 0, 2, 1'b0);

    // Bad CRC word: error with checking, good without.
    w = '{32'hA5BE7C01, 32'hCAFE, 32'hBEEF, 32'h3FFFFFFF, 32'hDEADBEEF};
    send_pkt(w, 0, 0, 1'b0);

    // Randomised mix of good and faulty packets.
    for (int n = 0; n < 200; n++) begin
      pick = $urandom_range(9, 0);
      len  = (pick < 6) ? 5 : $urandom_range(7, 1);
      w.delete();
      w.push_back(good_hdr());
      if (pick == 9) w[0][31:16] = $urandom_range(16'hFFFF, 0) ^ 16'h0001;
      for (int j = 1; j < len; j++) w.push_back($urandom);
      if (len >= 5) w[4] = (pick == 8) ? (Crc ^ ($urandom | 1)) : Crc;
      send_pkt(w, 0, 3, 1'b0);
    end

    // Back-to-back good packets past counter saturation.
    for (int n = 0; n < 300; n++) begin
      w = '{good_hdr(), $urandom, $urandom, $urandom, Crc};
      send_pkt(w, 0, 0, 1'b0);
    end
    check("good_saturated", gc[0], {CntW{1'b1}});

    // Clear coinciding with a good packet wins, then counting resumes.
    w = '{32'hA5BE9400, 32'h1, 32'h2, 32'h3, Crc};
    send_pkt(w, 0, 0, 1'b1);
    w = '{32'hA5BE8800, 32'h4, 32'h5, 32'h6, Crc};
    send_pkt(w, 1, 1, 1'b0);

    // Reset in the middle of a packet.
    send_beat(32'hA5BE8C00, 1'b0, 1'b0);
    send_beat(32'h00000064, 1'b0, 1'b0);
    send_beat(32'hFFFFFF9C, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    model_reset();
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    w = '{32'h40000010, Crc};
    send_pkt(w, 0, 0, 1'b0);
    w = '{32'hA5BE8C00, 32'h00000064, 32'hFFFFFF9C, 32'h40000010, Crc};
    send_pkt(w, 0, 1, 1'b0);

    idle(5);
    check("queue_drain", q0.size() + q1.size(), 0);
    check("busy_end", {bz[0], bz[1]}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
